// File: rtl/enc1s_rnd.sv
// AES enc/dec and SM4 round sequencer around one combinational enc1s op per cycle; done after N+1 cycles (N+2 with ENC1S_RND_PIPE_EN).
// Backpressure: ready=0 while busy and a start in that window is dropped; a start in the done cycle is accepted.
module enc1s (
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [4:0]  fn,
    output logic [31:0] rd
);
    localparam logic [2047:0] SM4_SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] s;
        p = '0;
        s = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ s;
            s = xt(s);
        end
        return p;
    endfunction

    // a^254 is the field inverse (and maps 0 to 0): build a^127, then square.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] e;
        e = a;
        for (int n = 0; n < 6; n++) e = gmul(gmul(e, e), a);
        return gmul(e, e);
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] rol32(input logic [31:0] a, input int n);
        logic [63:0] t;
        t = {a, a} << n;
        return t[63:32];
    endfunction

    logic [7:0]  x, gi, y, y2, y4, y8;
    logic [31:0] z;

    always_comb begin
        x  = rs2[8*fn[1:0] +: 8];
        gi = ginv((fn[4:3] == 2'b01) ? (rol8(x, 1) ^ rol8(x, 3) ^ rol8(x, 6) ^ 8'h05) : x);
        y  = gi;
        y2 = xt(gi);
        y4 = xt(y2);
        y8 = xt(y4);
        z  = '0;
        case (fn[4:3])
            2'b00: begin
                y  = gi ^ rol8(gi, 1) ^ rol8(gi, 2) ^ rol8(gi, 3) ^ rol8(gi, 4) ^ 8'h63;
                y2 = xt(y);
                z  = fn[2] ? {24'h0, y} : {y2 ^ y, y, y, y2};
            end
            2'b01: z = fn[2] ? {24'h0, y} : {y8 ^ y2 ^ y, y8 ^ y4 ^ y, y8 ^ y, y8 ^ y4 ^ y2};
            2'b10: begin
                y = SM4_SBOX[11'd2047 - {x, 3'b000} -: 8];
                z = {24'h0, y};
                z = fn[2] ? (z ^ rol32(z, 13) ^ rol32(z, 23))
                          : (z ^ rol32(z, 2) ^ rol32(z, 10) ^ rol32(z, 18) ^ rol32(z, 24));
            end
            default: z = '0;
        endcase
        rd = rs1 ^ rol32(z, 8*fn[1:0]);
    end
endmodule

module enc1s_rnd (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [1:0]   mode_i,
    input  logic         last_i,
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    output logic         ready_o,
    output logic         done_o,
    output logic         err_o,
    output logic [127:0] state_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;

`ifdef ENC1S_RND_PIPE_EN
    localparam fsm_t FIN_NEXT = DRAIN;
`else
    localparam fsm_t FIN_NEXT = IDLE;
`endif

    fsm_t         fsm;
    logic [3:0]   k;
    logic [1:0]   mode_q;
    logic         last_q;
    logic [127:0] st_q;
    logic [127:0] rk_q;
    logic [31:0]  t_q;
    logic [31:0]  acc;
    logic [95:0]  res;

    logic         iss_vld, iss_fin, iss_first;
    logic [4:0]   iss_fn;
    logic [1:0]   iss_j, widx;
    logic [31:0]  iss_rs1, iss_rs2;

    logic         ex_vld, ex_fin, ex_first;
    logic [4:0]   ex_fn;
    logic [1:0]   ex_j;
    logic [31:0]  ex_rs1, ex_rs2;
    logic [31:0]  op_rs1, op_rd;

    always_comb begin
        iss_vld   = (fsm == RUN);
        iss_fn    = {mode_q, last_q, k[1:0]};
        iss_j     = k[3:2];
        widx      = mode_q[0] ? (k[3:2] - k[1:0]) : (k[3:2] + k[1:0]);
        iss_fin   = mode_q[1] ? (k == 4'd3) : (k == 4'd15);
        iss_first = mode_q[1] ? (k == 4'd0) : (k[1:0] == 2'd0);
        iss_rs1   = mode_q[1] ? st_q[31:0] : rk_q[32*k[3:2] +: 32];
        iss_rs2   = mode_q[1] ? t_q : st_q[32*widx +: 32];
    end

`ifdef ENC1S_RND_PIPE_EN
    // The rs1 select is resolved after this stage, so each op sees the acc written by the one before.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld   <= 1'b0;
            ex_fin   <= 1'b0;
            ex_first <= 1'b0;
            ex_fn    <= '0;
            ex_j     <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
        end else begin
            ex_vld   <= iss_vld;
            ex_fin   <= iss_fin;
            ex_first <= iss_first;
            ex_fn    <= iss_fn;
            ex_j     <= iss_j;
            ex_rs1   <= iss_rs1;
            ex_rs2   <= iss_rs2;
        end
    end
`else
    always_comb begin
        ex_vld   = iss_vld;
        ex_fin   = iss_fin;
        ex_first = iss_first;
        ex_fn    = iss_fn;
        ex_j     = iss_j;
        ex_rs1   = iss_rs1;
        ex_rs2   = iss_rs2;
    end
`endif

    assign op_rs1 = ex_first ? ex_rs1 : acc;

    enc1s u_enc1s (
        .rs1 (op_rs1),
        .rs2 (ex_rs2),
        .fn  (ex_fn),
        .rd  (op_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            k       <= '0;
            mode_q  <= '0;
            last_q  <= 1'b0;
            st_q    <= '0;
            rk_q    <= '0;
            t_q     <= '0;
            acc     <= '0;
            res     <= '0;
            ready_o <= 1'b1;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            state_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start_i) begin
                        if (mode_i == 2'b11) begin
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                            state_o <= state_i;
                        end else begin
                            fsm     <= RUN;
                            k       <= '0;
                            ready_o <= 1'b0;
                            mode_q  <= mode_i;
                            last_q  <= last_i;
                            st_q    <= state_i;
                            rk_q    <= rkey_i;
                            t_q     <= state_i[63:32] ^ state_i[95:64] ^ state_i[127:96] ^ rkey_i[31:0];
                        end
                    end
                end
                RUN: begin
                    k <= k + 4'd1;
                    if (iss_fin) begin
                        k   <= '0;
                        fsm <= FIN_NEXT;
                    end
                end
                DRAIN:   fsm <= IDLE;
                default: fsm <= IDLE;
            endcase

            if (ex_vld) begin
                acc <= op_rd;
                if (!mode_q[1] && ex_fn[1:0] == 2'd3) begin
                    case (ex_j)
                        2'd0:    res[31:0]  <= op_rd;
                        2'd1:    res[63:32] <= op_rd;
                        2'd2:    res[95:64] <= op_rd;
                        default: ;
                    endcase
                end
                if (ex_fin) begin
                    done_o  <= 1'b1;
                    ready_o <= 1'b1;
                    state_o <= mode_q[1] ? {op_rd, st_q[127:32]} : {op_rd, res};
                end
            end
        end
    end
endmodule

// File: tb/tb_enc1s_rnd.sv
// Bench for enc1s_rnd: scoreboard of expected results/done cycles, checked whenever done_o pulses.
module tb_enc1s_rnd;
`ifdef ENC1S_RND_PIPE_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    typedef struct {
        int           cyc;
        logic         err;
        logic         chk;
        logic [127:0] st;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   mode = '0;
    logic         last = 1'b0;
    logic [127:0] st_in = '0;
    logic [127:0] rk_in = '0;
    logic         ready, done, err;
    logic [127:0] st_out;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];

    enc1s_rnd dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .mode_i  (mode),
        .last_i  (last),
        .state_i (st_in),
        .rkey_i  (rk_in),
        .ready_o (ready),
        .done_o  (done),
        .err_o   (err),
        .state_o (st_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done cyc=%0d state_o=%h", cyc, st_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total++;
                if (cyc !== e.cyc) begin
                    bad++; $display("FAIL done_cycle got=%0d want=%0d", cyc, e.cyc);
                end
                total++;
                if (err !== e.err) begin
                    bad++; $display("FAIL err_o got=%b want=%b", err, e.err);
                end
                if (e.chk) begin
                    total++;
                    if (st_out !== e.st) begin
                        bad++; $display("FAIL state_o got=%h want=%h", st_out, e.st);
                    end
                end
            end
        end
    end

    function automatic logic [127:0] bs128(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
        return r;
    endfunction

    function automatic int lat(input logic [1:0] m);
        if (m == 2'b11) return 1;
        return ((m == 2'b10) ? 5 : 17) + PX;
    endfunction

    // Called at posedge+1; start is high for exactly that cycle.
    task automatic issue(input logic [1:0] m, input logic l, input logic [127:0] s,
                         input logic [127:0] r, input logic chk, input logic [127:0] ex,
                         input logic push);
        exp_t e;
        mode = m; last = l; st_in = s; rk_in = r; start = 1'b1;
        if (push) begin
            e.cyc = cyc + lat(m); e.err = (m == 2'b11); e.chk = chk; e.st = ex;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        st_in = {$urandom, $urandom, $urandom, $urandom};
        rk_in = {$urandom, $urandom, $urandom, $urandom};
        mode  = 2'($urandom_range(0, 3));
        last  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done();
        if (done === 1'b1) return;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) return;
        end
        total++; bad++;
        $display("FAIL wait_done got=timeout want=done_o within 60 cycles");
    endtask

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (st_out !== '0) begin bad++; $display("FAIL reset_state got=%h want=0", st_out); end
    endtask

    task automatic test_aes_enc();
        align();
        issue(2'b00, 1'b0, bs128(128'h193de3bea0f4e22b9ac68d2ae9f84808),
              bs128(128'ha0fafe1788542cb123a339392a6c7605), 1'b1,
              bs128(128'ha49c7ff2689f352b6b5bea43026a5049), 1'b1);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", ready); end
        wait_done();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL done_ready got=%b want=1", ready); end
        align();
        issue(2'b00, 1'b1, bs128(128'heb40f21e592e38848ba113e71bc342d2),
              bs128(128'hd014f9a8c9ee2589e13f0cc8b6630ca6), 1'b1,
              bs128(128'h3925841d02dc09fbdc118597196a0b32), 1'b1);
        wait_done();
    endtask

    task automatic test_sm4();
        align();
        issue(2'b10, 1'b0, '0, '0, 1'b1, 128'h5b5b5b5b_00000000_00000000_00000000, 1'b1);
        wait_done();
        align();
        issue(2'b10, 1'b1, '0, '0, 1'b1, 128'h67676767_00000000_00000000_00000000, 1'b1);
        wait_done();
    endtask

    task automatic test_error();
        align();
        issue(2'b11, 1'b0, 128'h0123456789abcdef_fedcba9876543210, '0, 1'b1,
              128'h0123456789abcdef_fedcba9876543210, 1'b1);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL err_done got=%b want=1", done); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL err_ready got=%b want=1", ready); end
        wait_done();
    endtask

    task automatic test_busy_start();
        align();
        issue(2'b00, 1'b0, bs128(128'h193de3bea0f4e22b9ac68d2ae9f84808),
              bs128(128'ha0fafe1788542cb123a339392a6c7605), 1'b1,
              bs128(128'ha49c7ff2689f352b6b5bea43026a5049), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL cyc5_ready got=%b want=0", ready); end
        mode = 2'b10; last = 1'b0; st_in = 128'hffff; rk_in = 128'h1234; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (25) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        align();
        issue(2'b10, 1'b0, '0, '0, 1'b1, 128'h5b5b5b5b_00000000_00000000_00000000, 1'b1);
        wait_done();
        issue(2'b10, 1'b1, '0, '0, 1'b1, 128'h67676767_00000000_00000000_00000000, 1'b1);
        wait_done();
        issue(2'b00, 1'b1, bs128(128'heb40f21e592e38848ba113e71bc342d2),
              bs128(128'hd014f9a8c9ee2589e13f0cc8b6630ca6), 1'b1,
              bs128(128'h3925841d02dc09fbdc118597196a0b32), 1'b1);
        wait_done();
    endtask

    task automatic test_reset_abort();
        align();
        issue(2'b00, 1'b0, 128'h55, 128'haa, 1'b0, '0, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        total++; if (st_out !== '0) begin bad++; $display("FAIL abort_state got=%h want=0", st_out); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic test_dec_roundtrip();
        logic [127:0] s, enc;
        align();
        for (int n = 0; n < 1000; n++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            issue(2'b00, 1'b1, s, '0, 1'b0, '0, 1'b1);
            wait_done();
            enc = st_out;
            issue(2'b01, 1'b1, enc, '0, 1'b1, s, 1'b1);
            wait_done();
        end
    endtask

    initial begin
        test_reset();
        test_aes_enc();
        test_sm4();
        test_error();
        test_busy_start();
        test_back_to_back();
        test_reset_abort();
        test_dec_roundtrip();
        repeat (5) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL pending_results got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
